// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB transaction engine between NUM_REQ requesters, with NACK retry.
// Optional engine watchdog is built when SCCB_ARB_TIMEOUT_EN is defined.
module sccb_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 2_400_000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ-1:0]     rw_i,
  input  logic [24*NUM_REQ-1:0]  data_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic                   err_o,
  output logic [7:0]             rdata_o,
  output logic                   eng_start_o,
  output logic                   eng_rw_o,
  output logic [23:0]            eng_data_o,
  input  logic                   eng_done_i,
  input  logic                   eng_ack_error_i,
  input  logic [7:0]             eng_rdata_i
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, FINISH} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic                 rw_q, rw_d;
  logic [23:0]          data_q, data_d;
  logic [3:0]           retry_q, retry_d;
  logic                 err_q, err_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 start_q, start_d;
  logic                 tmo_hit;

  // Round-robin search starting just after the last owner.
  logic [PTR_W-1:0] pick;
  logic             found;
  always_comb begin
    logic [PTR_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef SCCB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts cycles of the current attempt; a retry re-enters ISSUE with a fresh count.
  always_comb begin
    tmo_d = '0;
    if ((state_q == ISSUE || state_q == BUSY) && !(state_q == BUSY && state_d == ISSUE))
      tmo_d = tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == ISSUE || state_q == BUSY) &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  // No watchdog in this build: a stuck engine keeps the grant.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    rw_d    = rw_q;
    data_d  = data_q;
    retry_d = retry_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d     = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          rw_d        = rw_i[pick];
          data_d      = data_i[pick*24 +: 24];
          retry_d     = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = FINISH;
        end else if (!eng_done_i) begin
          state_d = BUSY;
        end else begin
          start_d = 1'b1;
        end
      end
      BUSY: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = FINISH;
        end else if (eng_done_i) begin
          if (eng_ack_error_i && (retry_q < 4'(MAX_RETRY))) begin
            retry_d = retry_q + 4'd1;
            state_d = ISSUE;
          end else begin
            err_d   = eng_ack_error_i;
            rdata_d = eng_rdata_i;
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        gnt_d   = '0;
        ptr_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      owner_q <= '0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = (state_q == FINISH) ? gnt_q : '0;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign eng_start_o = start_q;
  assign eng_rw_o    = rw_q;
  assign eng_data_o  = data_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Randomized self-checking bench for sccb_arbiter with a behavioural SCCB engine and round-robin model.
module tb_sccb_arbiter;
  localparam int NR  = 3;
  localparam int MR  = 3;
  localparam int TMO = 100;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   req_i, rw_i, gnt_o, done_o;
  logic [24*NR-1:0] data_i;
  logic            err_o, eng_start_o, eng_rw_o;
  logic            eng_done_i, eng_ack_error_i;
  logic [7:0]      rdata_o, eng_rdata_i;
  logic [23:0]     eng_data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  sccb_arbiter #(.NUM_REQ(NR), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .rw_i(rw_i), .data_i(data_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .eng_start_o(eng_start_o), .eng_rw_o(eng_rw_o), .eng_data_o(eng_data_o),
    .eng_done_i(eng_done_i), .eng_ack_error_i(eng_ack_error_i), .eng_rdata_i(eng_rdata_i)
  );

  // Behavioural engine: accepts a start, works for a few cycles, NACKs the first nack_k attempts.
  bit          e_busy, start_prev;
  bit          eng_stuck = 1'b0;
  int          e_cnt;
  int          eng_lat = 0;
  int          start_cnt = 0;
  int          done_cnt = 0;
  int          nack_k = 0;
  int          nack_base = 0;
  logic [23:0] last_eng_data;
  logic        last_eng_rw;

  function automatic logic [7:0] rd_fn(input logic [15:0] a);
    if (a == 16'h300A) return 8'h56;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [NR-1:0] onehot(input int k);
    logic [NR-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      e_busy = 1'b0; eng_done_i = 1'b1; eng_ack_error_i = 1'b0; eng_rdata_i = 8'h00; start_prev = 1'b0;
    end else begin
      if (eng_start_o && !start_prev) start_cnt++;
      start_prev = eng_start_o;
      if (!e_busy) begin
        if (eng_start_o && eng_done_i) begin
          e_busy = 1'b1; eng_done_i = 1'b0;
          last_eng_data = eng_data_o; last_eng_rw = eng_rw_o;
          e_cnt = (eng_lat > 0) ? eng_lat : int'($urandom_range(1, 4));
        end
      end else if (!eng_stuck) begin
        if (e_cnt > 1) e_cnt--;
        else begin
          e_busy = 1'b0; eng_done_i = 1'b1;
          eng_ack_error_i = ((done_cnt - nack_base) < nack_k);
          eng_rdata_i = last_eng_rw ? rd_fn(last_eng_data[23:8]) : 8'($urandom);
          done_cnt++;
        end
      end
    end
  end

  task automatic wait_done(input int limit, output int owner, output bit ok);
    owner = -1; ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk_i);
      if (done_o != '0) begin
        ok = 1'b1;
        for (int i = 0; i < NR; i++) if (done_o[i]) owner = i;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0; req_i = '0; rw_i = '0; data_i = '0;
    eng_stuck = 1'b0; eng_lat = 0; nack_k = 0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_i = '0; rw_i = '0; data_i = '0;
    repeat (3) @(negedge clk_i);
    checks++; if (gnt_o !== '0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt_o); end
    checks++; if (done_o !== '0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
    checks++; if (rdata_o !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", rdata_o); end
    checks++; if (eng_start_o !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", eng_start_o); end
    checks++; if ({eng_rw_o, eng_data_o} !== 25'h0) begin errors++; $display("FAIL reset_eng got %b/%h want 0/000000", eng_rw_o, eng_data_o); end
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++; if (gnt_o !== '0) begin errors++; $display("FAIL idle_gnt got %b want 0", gnt_o); end
  endtask

  task automatic test_single_write();
    int own; bit ok, got; int s0;
    do_reset();
    data_i[23:0] = 24'h300882; rw_i = '0; nack_k = 0; nack_base = done_cnt; s0 = start_cnt;
    req_i = onehot(0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin @(negedge clk_i); if (gnt_o != '0) got = 1'b1; end
    checks++; if (!got) begin errors++; $display("FAIL wr_grant got none want %b", onehot(0)); end
    checks++; if (eng_start_o !== 1'b0) begin errors++; $display("FAIL wr_start_lead got %b want 0", eng_start_o); end
    @(negedge clk_i);
    checks++; if (eng_start_o !== 1'b1) begin errors++; $display("FAIL wr_start_follow got %b want 1", eng_start_o); end
    wait_done(100, own, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_done got timeout want pulse"); end
    checks++; if (done_o !== onehot(0)) begin errors++; $display("FAIL wr_done_vec got %b want %b", done_o, onehot(0)); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", err_o); end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL wr_starts got %0d want 1", start_cnt - s0); end
    checks++; if (last_eng_data !== 24'h300882) begin errors++; $display("FAIL wr_eng_data got %h want 300882", last_eng_data); end
    req_i = '0;
    @(negedge clk_i);
    checks++; if (done_o !== '0) begin errors++; $display("FAIL wr_done_width got %b want 0", done_o); end
  endtask

  task automatic test_read();
    int own; bit ok;
    data_i[47:24] = {16'h300A, 8'h00}; rw_i = onehot(1); nack_k = 0; nack_base = done_cnt;
    req_i = onehot(1);
    wait_done(200, own, ok);
    checks++; if (done_o !== onehot(1)) begin errors++; $display("FAIL rd_done got %b want %b", done_o, onehot(1)); end
    checks++; if (rdata_o !== 8'h56) begin errors++; $display("FAIL rd_data got %h want 56", rdata_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", err_o); end
    checks++; if (last_eng_rw !== 1'b1) begin errors++; $display("FAIL rd_eng_rw got %b want 1", last_eng_rw); end
    req_i = '0; rw_i = '0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_contention();
    int own; bit ok;
    do_reset();
    data_i[23:0] = 24'h111111; data_i[47:24] = 24'h222222;
    req_i = 3'b011;
    for (int t = 0; t < 4; t++) begin
      wait_done(200, own, ok);
      checks++; if (own != t % 2) begin errors++; $display("FAIL rr_order txn %0d got %0d want %0d", t, own, t % 2); end
    end
    req_i = '0;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_nack();
    int own; bit ok; int s0;
    data_i[23:0] = 24'h301234; rw_i = '0;
    nack_k = 2; nack_base = done_cnt; s0 = start_cnt;
    req_i = onehot(0);
    wait_done(400, own, ok);
    checks++; if (start_cnt - s0 != 3) begin errors++; $display("FAIL nack2_starts got %0d want 3", start_cnt - s0); end
    checks++; if (err_o !== 1'b0 || !ok) begin errors++; $display("FAIL nack2_err got %b want 0", err_o); end
    req_i = '0;
    repeat (2) @(negedge clk_i);
    nack_k = 99; nack_base = done_cnt; s0 = start_cnt;
    req_i = onehot(0);
    wait_done(400, own, ok);
    checks++; if (start_cnt - s0 != MR + 1) begin errors++; $display("FAIL nackall_starts got %0d want %0d", start_cnt - s0, MR + 1); end
    checks++; if (err_o !== 1'b1 || !ok) begin errors++; $display("FAIL nackall_err got %b want 1", err_o); end
    req_i = '0; nack_k = 0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    int own; bit ok, got;
    do_reset();
    eng_lat = 20; rw_i = onehot(0); data_i[23:0] = 24'hABCDEF;
    req_i = onehot(0);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk_i); #1;
      if (gnt_o != '0 && eng_done_i == 1'b0 && eng_start_o == 1'b0) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL rstmid_busy got not reached want busy"); end
    rst_i = 1'b0;
    #1;
    checks++; if ({gnt_o, done_o, err_o, rdata_o, eng_start_o, eng_rw_o, eng_data_o} !== '0)
      begin errors++; $display("FAIL rstmid_outputs got gnt %b start %b rw %b data %h want all 0", gnt_o, eng_start_o, eng_rw_o, eng_data_o); end
    req_i = 3'b011; rw_i = '0; eng_lat = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    wait_done(200, own, ok);
    checks++; if (own != 0) begin errors++; $display("FAIL rstmid_first got %0d want 0", own); end
    req_i = '0;
    repeat (3) @(negedge clk_i);
  endtask

`ifdef SCCB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n; bit got;
    do_reset();
    eng_stuck = 1'b1; data_i[23:0] = 24'h123456; rw_i = onehot(0);
    req_i = onehot(0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin @(negedge clk_i); if (gnt_o != '0) got = 1'b1; end
    n = 0;
    while (done_o == '0 && n < 3 * TMO) begin @(negedge clk_i); n++; end
    checks++; if (n != TMO || !got) begin errors++; $display("FAIL tmo_cycles got %0d want %0d", n, TMO); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", err_o); end
    checks++; if (rdata_o !== 8'h00) begin errors++; $display("FAIL tmo_rdata got %h want 00", rdata_o); end
    checks++; if (eng_start_o !== 1'b0) begin errors++; $display("FAIL tmo_start got %b want 0", eng_start_o); end
    do_reset();
  endtask
`else
  task automatic test_stuck();
    int seen;
    do_reset();
    eng_stuck = 1'b1; data_i[23:0] = 24'h123456;
    req_i = onehot(0);
    seen = 0;
    repeat (300) begin @(negedge clk_i); if (done_o != '0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL stuck_done got %0d pulses want 0", seen); end
    checks++; if (gnt_o !== onehot(0)) begin errors++; $display("FAIL stuck_gnt got %b want %b", gnt_o, onehot(0)); end
    do_reset();
  endtask
`endif

  task automatic test_random();
    int own, exp_own, ptr_m, k, s0, idx; bit ok;
    logic [NR-1:0] pending;
    logic [23:0] dmem [NR];
    logic [NR-1:0] rwm;
    do_reset();
    ptr_m = NR - 1; pending = '0; rwm = '0;
    for (int t = 0; t < 40; t++) begin
      if (pending == '0) begin
        pending = NR'($urandom_range(1, (1 << NR) - 1));
        for (int r = 0; r < NR; r++) begin
          dmem[r] = 24'($urandom);
          rwm[r] = 1'($urandom_range(0, 1));
          data_i[r*24 +: 24] = dmem[r];
        end
        rw_i = rwm;
        req_i = pending;
      end
      k = $urandom_range(0, 5);
      nack_k = k; nack_base = done_cnt; s0 = start_cnt;
      exp_own = -1;
      for (int i = 1; i <= NR; i++) begin
        idx = (ptr_m + i) % NR;
        if (exp_own < 0 && pending[idx]) exp_own = idx;
      end
      wait_done(1000, own, ok);
      checks++; if (!ok || own != exp_own) begin errors++; $display("FAIL rnd_owner txn %0d got %0d want %0d", t, own, exp_own); end
      checks++; if (err_o !== (k > MR)) begin errors++; $display("FAIL rnd_err txn %0d got %b want %b", t, err_o, (k > MR)); end
      checks++; if (start_cnt - s0 != ((k < MR) ? k : MR) + 1) begin errors++; $display("FAIL rnd_starts txn %0d got %0d want %0d", t, start_cnt - s0, ((k < MR) ? k : MR) + 1); end
      checks++; if (last_eng_data !== dmem[exp_own]) begin errors++; $display("FAIL rnd_eng_data txn %0d got %h want %h", t, last_eng_data, dmem[exp_own]); end
      if (rwm[exp_own] && k <= MR) begin
        checks++; if (rdata_o !== rd_fn(dmem[exp_own][23:8])) begin errors++; $display("FAIL rnd_rdata txn %0d got %h want %h", t, rdata_o, rd_fn(dmem[exp_own][23:8])); end
      end
      pending[exp_own] = 1'b0;
      req_i = pending;
      ptr_m = exp_own;
    end
    req_i = '0; nack_k = 0;
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_nack();
    test_reset_mid();
`ifdef SCCB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_stuck();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sccb_arbiter.md
# sccb_arbiter

Shares the single SCCB transaction engine between several register-access requesters, such as the power-up setup sequencer and a runtime exposure/AWB tuning block. It sits between those requesters and the SCCB controller in the camera interface. It grants the bus round-robin, sequences the engine's start/done handshake, and retries NACKed transfers. It returns a per-requester completion pulse, error flag and read data.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- MAX_RETRY, 3, extra attempts after an ack error (0..15)
- TIMEOUT_CYCLES, 2_400_000, watchdog limit in clk_i cycles while the engine is busy (used only with SCCB_ARB_TIMEOUT_EN)

- clk_i  input  1  main clock
- rst_i  input  1  asynchronous, active-low reset (0 = reset)
- req_i  input  NUM_REQ  per-requester request level
- rw_i  input  NUM_REQ  per-requester op: 1 = read, 0 = write
- data_i  input  24*NUM_REQ  per-requester {reg_addr[15:0], wdata[7:0]}; requester k uses bits [24k+23:24k]
- gnt_o  output  NUM_REQ  one-hot; high for the whole ownership window
- done_o  output  NUM_REQ  one-cycle completion pulse to the owner
- err_o  output  1  ack error or timeout; valid only while any done_o bit is high
- rdata_o  output  8  read data; valid while done_o is high and the op was a read
- eng_start_o  output  1  start request to the engine
- eng_rw_o  output  1  latched op
- eng_data_o  output  24  latched address/data
- eng_done_i  input  1  engine idle/complete level (high = idle)
- eng_ack_error_i  input  1  engine ack error; valid when eng_done_i rises
- eng_rdata_i  input  8  engine read data

## Operation
- State machine has four states: IDLE, ISSUE, BUSY, FINISH.
- IDLE
  - If any req_i bit is high, pick the first requester at or after ptr+1 (mod NUM_REQ).
  - Latch that requester's rw and data, set its gnt_o bit, clear retry_cnt, go to ISSUE.
- ISSUE
  - Drive eng_start_o = 1.
  - When eng_done_i is sampled low (engine accepted the request), go to BUSY.
- BUSY
  - Hold eng_start_o = 0.
  - When eng_done_i is sampled high:
    - If eng_ack_error_i = 1 and retry_cnt < MAX_RETRY: increment retry_cnt, go to ISSUE.
    - Otherwise capture the error flag and eng_rdata_i, go to FINISH.
- FINISH
  - Pulse done_o[owner] for one cycle, with err_o and rdata_o valid in the same cycle.
  - Clear gnt_o, set ptr = owner, go to IDLE.
- Requester rules:
  - Hold req, rw and data stable until done_o.
  - Lowering req mid-transfer does not abort; the done pulse is still issued.
  - A req still high in the cycle after done_o counts as a new request, but arbitration ptr+1 lets other requesters go first.
- ptr resets to NUM_REQ-1, so requester 0 has first priority after reset.
- retry_cnt is 4 bits; the total attempt count is bounded by MAX_RETRY+1.

## Timing
- Reset values: gnt_o = 0, done_o = 0, err_o = 0, rdata_o = 0, eng_start_o = 0, eng_rw_o = 0, eng_data_o = 0, state = IDLE.
- Reset asserted mid-transfer drops eng_start_o immediately, and the pending requester gets no done pulse.
- Request-to-grant latency: req_i high at edge n gives gnt_o high after edge n+1; eng_start_o is high after edge n+2.
- FINISH lasts exactly 1 cycle; the next grant is issued no earlier than 1 cycle after done_o.
- Simultaneous requests are resolved in a single cycle by round-robin; no requester waits more than NUM_REQ-1 transactions.
- If eng_done_i is already low when entering ISSUE, the move to BUSY happens on the next edge.

## Configuration
- SCCB_ARB_TIMEOUT_EN defined:
  - A counter runs while in ISSUE or BUSY and restarts on each retry.
  - Reaching TIMEOUT_CYCLES forces eng_start_o = 0 and enters FINISH with err_o = 1 and rdata_o = 0; no further retry is attempted.
- SCCB_ARB_TIMEOUT_EN undefined: no counter is built, and a stuck engine holds the grant indefinitely.

## Test plan
- Single write: req_i = 01, data 0x3008_82, engine model completes with no error -> eng_start_o is seen once, done_o = 01 for exactly 1 cycle, err_o = 0.
- Read: requester 1 reads 0x300A, engine returns 0x56 -> done_o = 10, rdata_o = 0x56.
- Contention: req_i = 11 held continuously after reset -> grant order 0, 1, 0, 1 over four transactions.
- NACK retry with MAX_RETRY = 3:
  - Engine NACKs twice, then ACKs -> 3 start pulses, err_o = 0.
  - Engine always NACKs -> 4 start pulses, err_o = 1.
- Timeout with SCCB_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES = 100: eng_done_i held low -> done_o pulses with err_o = 1 at 100 cycles after entering ISSUE.
- Reset mid-transfer: rst_i pulled low while in BUSY -> all outputs are 0 in the same cycle, and requester 0 is granted first after release.
